// File: rtl/wb_port_if.sv
// Bundles the write-back sources and the register-file write port of wb_port_arbiter.
// The arbiter connects to the slave modport and the driving environment connects to the master modport.
interface wb_port_if #(
   parameter int DATA_W = 32
);
   logic [4:0]        p_rd;
   logic [DATA_W-1:0] p_data;
   logic              p_stall;
   logic              s_valid;
   logic [4:0]        s_rd;
   logic [DATA_W-1:0] s_data;
   logic              s_ready;
   logic              rf_we;
   logic [4:0]        rf_waddr;
   logic [DATA_W-1:0] rf_wdata;

   modport master (
      output p_rd, p_data, s_valid, s_rd, s_data,
      input  p_stall, s_ready, rf_we, rf_waddr, rf_wdata
   );

   modport slave (
      input  p_rd, p_data, s_valid, s_rd, s_data,
      output p_stall, s_ready, rf_we, rf_waddr, rf_wdata
   );
endinterface

// File: rtl/wb_port_arbiter.sv
// Shares one register-file write port between the primary pipeline write-back and a buffered secondary unit.
// Define WB_STARVE_EN to add the starvation guard that forces a FIFO write by stalling the primary source.
module wb_port_arbiter #(
   parameter int DATA_W     = 32,
   parameter int DEPTH      = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic     clk,
   input  logic     rst_n,
   wb_port_if.slave bus
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   typedef enum logic [1:0] {GNT_NONE, GNT_FIFO, GNT_PRI, GNT_BYP} gnt_e;

   logic [CW-1:0]     r_fifo_cnt;
   logic [PW-1:0]     r_wr_ptr;
   logic [PW-1:0]     r_rd_ptr;
   logic [4:0]        r_mem_rd   [DEPTH];
   logic [DATA_W-1:0] r_mem_data [DEPTH];
   logic              r_rf_we;
   logic [4:0]        r_rf_waddr;
   logic [DATA_W-1:0] r_rf_wdata;

   gnt_e              w_gnt;
   logic              w_fifo_empty;
   logic              w_s_acc;
   logic              w_push;
   logic              w_pop;
   logic              w_force;
   logic [4:0]        w_gnt_rd;
   logic [DATA_W-1:0] w_gnt_data;

   assign w_fifo_empty = (r_fifo_cnt == '0);
   assign bus.s_ready  = (r_fifo_cnt != CW'(DEPTH));
   assign w_s_acc      = bus.s_valid && bus.s_ready;

`ifdef WB_STARVE_EN
   localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
   logic [SW-1:0] r_starve_cnt;

   assign w_force = (r_starve_cnt == SW'(STARVE_MAX)) && !w_fifo_empty;

   // Counts cycles the current FIFO head has been passed over.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_starve_cnt <= '0;
      else if (w_fifo_empty || w_pop)
         r_starve_cnt <= '0;
      else if (r_starve_cnt != SW'(STARVE_MAX))
         r_starve_cnt <= r_starve_cnt + 1'b1;
   end
`else
   assign w_force = 1'b0;
`endif

   assign bus.p_stall = w_force;

   always_comb begin
      w_gnt = GNT_NONE;
      if (w_force)
         w_gnt = GNT_FIFO;
      else if (bus.p_rd != 5'd0)
         w_gnt = GNT_PRI;
      else if (!w_fifo_empty)
         w_gnt = GNT_FIFO;
      else if (w_s_acc && (bus.s_rd != 5'd0))
         w_gnt = GNT_BYP;
   end

   assign w_pop  = (w_gnt == GNT_FIFO);
   // Requests to r0 are swallowed here: never stored, never written.
   assign w_push = w_s_acc && (bus.s_rd != 5'd0) && (w_gnt != GNT_BYP);

   always_comb begin
      w_gnt_rd   = bus.p_rd;
      w_gnt_data = bus.p_data;
      if (w_gnt == GNT_FIFO) begin
         w_gnt_rd   = r_mem_rd[r_rd_ptr];
         w_gnt_data = r_mem_data[r_rd_ptr];
      end else if (w_gnt == GNT_BYP) begin
         w_gnt_rd   = bus.s_rd;
         w_gnt_data = bus.s_data;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_rd[r_wr_ptr]   <= bus.s_rd;
         r_mem_data[r_wr_ptr] <= bus.s_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fifo_cnt <= '0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
      end else begin
         if (w_push)
            r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_push && !w_pop)
            r_fifo_cnt <= r_fifo_cnt + 1'b1;
         else if (w_pop && !w_push)
            r_fifo_cnt <= r_fifo_cnt - 1'b1;
      end
   end

   // Address and data hold their last value through no-grant cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rf_we    <= 1'b0;
         r_rf_waddr <= '0;
         r_rf_wdata <= '0;
      end else begin
         r_rf_we <= (w_gnt != GNT_NONE);
         if (w_gnt != GNT_NONE) begin
            r_rf_waddr <= w_gnt_rd;
            r_rf_wdata <= w_gnt_data;
         end
      end
   end

   assign bus.rf_we    = r_rf_we;
   assign bus.rf_waddr = r_rf_waddr;
   assign bus.rf_wdata = r_rf_wdata;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed scenarios plus a randomized run against a queue-based model.
// Build with or without WB_STARVE_EN; expectations follow the same macro.
module tb_wb_port_arbiter;
   localparam int DATA_W     = 32;
   localparam int DEPTH      = 2;
   localparam int STARVE_MAX = 4;
`ifdef WB_STARVE_EN
   localparam bit STARVE_ON = 1'b1;
`else
   localparam bit STARVE_ON = 1'b0;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   wb_port_if #(.DATA_W(DATA_W)) bus ();

   wb_port_arbiter #(.DATA_W(DATA_W), .DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct packed {
      logic [4:0]        rd;
      logic [DATA_W-1:0] data;
   } ent_t;

   ent_t              q[$];
   int                starve;
   logic              exp_we, exp_ready, exp_stall;
   logic [4:0]        exp_addr;
   logic [DATA_W-1:0] exp_data;
   logic              act_we, act_ready, act_stall;
   logic [4:0]        act_addr;
   logic [DATA_W-1:0] act_data;
   int                n_cmp = 0;
   int                n_err = 0;

   task automatic model_reset();
      q.delete();
      starve   = 0;
      exp_we   = 1'b0;
      exp_addr = '0;
      exp_data = '0;
   endtask

   // One clock cycle: drive inputs, sample combinational outputs, advance the model, sample rf_* after the edge.
   task automatic step(input logic [4:0] prd, input logic [DATA_W-1:0] pdata,
                       input logic sv, input logic [4:0] srd, input logic [DATA_W-1:0] sdata);
      bit                force_g, acc, pop, push, gnt;
      logic [4:0]        g_rd;
      logic [DATA_W-1:0] g_data;
      @(negedge clk);
      bus.p_rd = prd; bus.p_data = pdata;
      bus.s_valid = sv; bus.s_rd = srd; bus.s_data = sdata;
      #1;
      act_ready = bus.s_ready;
      act_stall = bus.p_stall;
      exp_ready = (q.size() != DEPTH);
      force_g   = STARVE_ON && (q.size() > 0) && (starve == STARVE_MAX);
      exp_stall = force_g;
      acc    = sv && exp_ready;
      gnt    = 1'b1;
      pop    = 1'b0;
      g_rd   = prd;
      g_data = pdata;
      if (force_g) pop = 1'b1;
      else if (prd != 0) begin end
      else if (q.size() > 0) pop = 1'b1;
      else if (acc && srd != 0) begin g_rd = srd; g_data = sdata; acc = 1'b0; end
      else gnt = 1'b0;
      if (pop) begin g_rd = q[0].rd; g_data = q[0].data; end
      push = acc && (srd != 0);
      if (q.size() == 0 || pop) starve = 0;
      else if (starve < STARVE_MAX) starve++;
      if (pop) void'(q.pop_front());
      if (push) q.push_back({srd, sdata});
      exp_we = gnt;
      if (gnt) begin exp_addr = g_rd; exp_data = g_data; end
      @(posedge clk);
      #1;
      act_we   = bus.rf_we;
      act_addr = bus.rf_waddr;
      act_data = bus.rf_wdata;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.p_rd = 5'd3; bus.p_data = 32'h3333_0003;
      bus.s_valid = 1'b1; bus.s_rd = 5'd0; bus.s_data = '0;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++; if (bus.rf_we !== 1'b0) begin n_err++; $display("FAIL reset_we: got %b want 0", bus.rf_we); end
      n_cmp++; if (bus.rf_waddr !== 5'd0) begin n_err++; $display("FAIL reset_waddr: got %0d want 0", bus.rf_waddr); end
      n_cmp++; if (bus.s_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", bus.s_ready); end
      n_cmp++; if (bus.p_stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", bus.p_stall); end
      model_reset();
      #1 rst_n = 1'b1;
      step(5'd3, 32'h3333_0003, 1'b1, 5'd0, '0);
      n_cmp++; if (act_we !== 1'b1 || act_addr !== 5'd3 || act_data !== 32'h3333_0003) begin
         n_err++; $display("FAIL first_write: got we=%b a=%0d d=%h want we=1 a=3 d=33330003", act_we, act_addr, act_data);
      end
   endtask

   task automatic test_bypass();
      step(5'd0, '0, 1'b1, 5'd7, 32'hA5A5_0001);
      n_cmp++; if (act_we !== 1'b1 || act_addr !== 5'd7 || act_data !== 32'hA5A5_0001) begin
         n_err++; $display("FAIL bypass: got we=%b a=%0d d=%h want we=1 a=7 d=a5a50001", act_we, act_addr, act_data);
      end
      step(5'd0, '0, 1'b0, 5'd0, '0);
      n_cmp++; if (act_we !== 1'b0 || act_ready !== 1'b1) begin
         n_err++; $display("FAIL bypass_nopush: got we=%b rdy=%b want we=0 rdy=1", act_we, act_ready);
      end
      n_cmp++; if (act_addr !== 5'd7 || act_data !== 32'hA5A5_0001) begin
         n_err++; $display("FAIL hold_addr: got a=%0d d=%h want a=7 d=a5a50001", act_addr, act_data);
      end
   endtask

   task automatic test_pri_then_fifo();
      step(5'd5, 32'h0000_0505, 1'b1, 5'd9, 32'h0000_0909);
      n_cmp++; if (act_we !== 1'b1 || act_addr !== 5'd5 || act_data !== 32'h0000_0505) begin
         n_err++; $display("FAIL pri_first: got we=%b a=%0d d=%h want we=1 a=5 d=00000505", act_we, act_addr, act_data);
      end
      step(5'd0, '0, 1'b0, 5'd0, '0);
      n_cmp++; if (act_we !== 1'b1 || act_addr !== 5'd9 || act_data !== 32'h0000_0909) begin
         n_err++; $display("FAIL fifo_next: got we=%b a=%0d d=%h want we=1 a=9 d=00000909", act_we, act_addr, act_data);
      end
   endtask

   task automatic test_fifo_full();
      logic [2:0] rdy_seen;
      for (int i = 0; i < 3; i++) begin
         step(5'd6, 32'h0600 + i, 1'b1, 5'(10 + i), 32'h1000 + i);
         rdy_seen[i] = act_ready;
      end
      n_cmp++; if (rdy_seen !== 3'b011) begin
         n_err++; $display("FAIL full_ready: got %b want 011 (third offer refused)", rdy_seen);
      end
      for (int i = 0; i < 20 && q.size() > 0; i++) begin
         step((i < 2) ? 5'd6 : 5'd0, 32'h0600, 1'b0, 5'd0, '0);
         n_cmp++; if ({act_we, act_addr, act_data, act_ready, act_stall} !== {exp_we, exp_addr, exp_data, exp_ready, exp_stall}) begin
            n_err++; $display("FAIL full_drain[%0d]: got we=%b a=%0d d=%h rdy=%b stl=%b want we=%b a=%0d d=%h rdy=%b stl=%b",
               i, act_we, act_addr, act_data, act_ready, act_stall, exp_we, exp_addr, exp_data, exp_ready, exp_stall);
         end
      end
   endtask

   task automatic test_starve();
      int n_stall = 0;
      int first   = -1;
      for (int i = 0; i < 12; i++) begin
         step(5'd4, 32'h0404_0404, (i == 0), 5'd12, 32'h0C0C_0C0C);
         if (act_stall) begin n_stall++; if (first < 0) first = i; end
         n_cmp++; if ({act_we, act_addr, act_data, act_stall} !== {exp_we, exp_addr, exp_data, exp_stall}) begin
            n_err++; $display("FAIL starve[%0d]: got we=%b a=%0d d=%h stl=%b want we=%b a=%0d d=%h stl=%b",
               i, act_we, act_addr, act_data, act_stall, exp_we, exp_addr, exp_data, exp_stall);
         end
      end
      n_cmp++; if (n_stall !== (STARVE_ON ? 1 : 0) || first !== (STARVE_ON ? 5 : -1)) begin
         n_err++; $display("FAIL starve_count: got stalls=%0d at %0d want %0d at %0d",
            n_stall, first, STARVE_ON ? 1 : 0, STARVE_ON ? 5 : -1);
      end
      for (int i = 0; i < 4; i++) step(5'd0, '0, 1'b0, 5'd0, '0);
   endtask

   task automatic test_zero_rd();
      step(5'd0, '0, 1'b1, 5'd0, 32'h5555_5555);
      n_cmp++; if (act_ready !== 1'b1 || act_we !== 1'b0) begin
         n_err++; $display("FAIL zero_rd: got rdy=%b we=%b want rdy=1 we=0", act_ready, act_we);
      end
      step(5'd0, '0, 1'b0, 5'd0, '0);
      n_cmp++; if (act_we !== 1'b0 || act_ready !== 1'b1) begin
         n_err++; $display("FAIL zero_rd_after: got we=%b rdy=%b want we=0 rdy=1", act_we, act_ready);
      end
   endtask

   task automatic test_random();
      logic [4:0]        prd = '0;
      logic [DATA_W-1:0] pdata = '0;
      bit                hold = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (!hold) begin
            prd   = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            pdata = $urandom;
         end
         step(prd, pdata, 1'($urandom_range(0, 1)),
              ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)), $urandom);
         hold = act_stall;
         n_cmp++; if ({act_we, act_addr, act_data, act_ready, act_stall} !== {exp_we, exp_addr, exp_data, exp_ready, exp_stall}) begin
            n_err++; $display("FAIL rand[%0d]: got we=%b a=%0d d=%h rdy=%b stl=%b want we=%b a=%0d d=%h rdy=%b stl=%b",
               i, act_we, act_addr, act_data, act_ready, act_stall, exp_we, exp_addr, exp_data, exp_ready, exp_stall);
         end
      end
   endtask

   task automatic test_reset_midop();
      step(5'd8, 32'h0808, 1'b1, 5'd20, 32'h2020);
      step(5'd8, 32'h0808, 1'b1, 5'd21, 32'h2121);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_cmp++; if (bus.rf_we !== 1'b0 || bus.s_ready !== 1'b1 || bus.p_stall !== 1'b0) begin
         n_err++; $display("FAIL midreset: got we=%b rdy=%b stl=%b want we=0 rdy=1 stl=0", bus.rf_we, bus.s_ready, bus.p_stall);
      end
      model_reset();
      bus.p_rd = '0; bus.s_valid = 1'b0;
      @(posedge clk);
      #2 rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step(5'd0, '0, 1'b0, 5'd0, '0);
         n_cmp++; if (act_we !== 1'b0 || act_we !== exp_we) begin
            n_err++; $display("FAIL midreset_discard[%0d]: got we=%b want we=0", i, act_we);
         end
      end
   endtask

   initial begin
      bus.p_rd = '0; bus.p_data = '0; bus.s_valid = 1'b0; bus.s_rd = '0; bus.s_data = '0;
      model_reset();
      test_reset();
      test_bypass();
      test_pri_then_fifo();
      test_fifo_full();
      test_starve();
      test_zero_rd();
      test_random();
      test_reset_midop();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
